// File: rtl/keypad_key_capture.sv
// Key capture stage behind the keypad scanner: synchronizes the decoded key,
// debounces press and release, and keeps a two-digit (current, previous) history.
module keypad_key_capture #(
  parameter  int DEBOUNCE_CYCLES = 50000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyInput,
  input  logic       keyInputValid,
  output logic [3:0] curDigit,
  output logic [3:0] prevDigit,
  output logic       newKey,
  output logic       keyHeld
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       sync_meta_q, sync_meta_d;
  logic [4:0]       sync_out_q, sync_out_d;
  state_t           state_q, state_d;
  logic [3:0]       cand_key_q, cand_key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cur_digit_q, cur_digit_d;
  logic [3:0]       prev_digit_q, prev_digit_d;
  logic             new_key_q, new_key_d;
  logic             key_held_q, key_held_d;

  logic             sync_valid;
  logic [3:0]       sync_key;

  // Two-flop synchronizer; multi-bit skew is harmless because acceptance needs stability.
  always_comb begin
    sync_meta_d = {keyInputValid, keyInput};
    sync_out_d  = sync_meta_q;
  end

  assign sync_valid = sync_out_q[4];
  assign sync_key   = sync_out_q[3:0];

  // Debounce FSM: next state, counter, digit history and output pulses.
  always_comb begin
    state_d      = state_q;
    cand_key_d   = cand_key_q;
    cnt_d        = cnt_q;
    cur_digit_d  = cur_digit_q;
    prev_digit_d = prev_digit_q;
    new_key_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sync_valid) begin
          cand_key_d = sync_key;
          cnt_d      = CNT_ZERO;
          state_d    = ST_DEB_PRESS;
        end else begin
          cnt_d      = CNT_ZERO;
        end
      end

      ST_DEB_PRESS: begin
        if (!sync_valid || (sync_key != cand_key_q)) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d        = CNT_ZERO;
          prev_digit_d = cur_digit_q;
          cur_digit_d  = cand_key_q;
          new_key_d    = 1'b1;
          state_d      = ST_HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A different valid key here is a roll-over and is deliberately ignored.
      ST_HELD: begin
        if (!sync_valid) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_DEB_RELEASE;
        end else begin
          state_d = ST_HELD;
        end
      end

      ST_DEB_RELEASE: begin
        if (sync_valid) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_HELD;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase

    key_held_d = (state_d == ST_HELD) || (state_d == ST_DEB_RELEASE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_q  <= 5'd0;
      sync_out_q   <= 5'd0;
      state_q      <= ST_IDLE;
      cand_key_q   <= 4'd0;
      cnt_q        <= CNT_ZERO;
      cur_digit_q  <= 4'd0;
      prev_digit_q <= 4'd0;
      new_key_q    <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      sync_meta_q  <= sync_meta_d;
      sync_out_q   <= sync_out_d;
      state_q      <= state_d;
      cand_key_q   <= cand_key_d;
      cnt_q        <= cnt_d;
      cur_digit_q  <= cur_digit_d;
      prev_digit_q <= prev_digit_d;
      new_key_q    <= new_key_d;
      key_held_q   <= key_held_d;
    end
  end

  assign curDigit  = cur_digit_q;
  assign prevDigit = prev_digit_q;
  assign newKey    = new_key_q;
  assign keyHeld   = key_held_q;

endmodule

// File: tb/tb_keypad_key_capture.sv
// Directed bench for keypad_key_capture with DEBOUNCE_CYCLES=4: press latency is
// 6 edges after the first sampling edge, so newKey shows on the 7th step.
module tb_keypad_key_capture;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keyInput;
  logic       keyInputValid;
  logic [3:0] curDigit;
  logic [3:0] prevDigit;
  logic       newKey;
  logic       keyHeld;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  keypad_key_capture #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .reset        (reset),
    .keyInput     (keyInput),
    .keyInputValid(keyInputValid),
    .curDigit     (curDigit),
    .prevDigit    (prevDigit),
    .newKey       (newKey),
    .keyHeld      (keyHeld)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, observe at the next falling edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] k);
    reset         = rst;
    keyInputValid = v;
    keyInput      = k;
    @(posedge clk);
    @(negedge clk);
    if (newKey === 1'b1) pulses++;
  endtask

  task automatic steps(input int n, input logic v, input logic [3:0] k);
    for (int i = 0; i < n; i++) step(1'b0, v, k);
  endtask

  task automatic check_digits(input string tag, input logic [3:0] cur, input logic [3:0] prev);
    check_eq({tag, "_cur"}, curDigit, cur);
    check_eq({tag, "_prev"}, prevDigit, prev);
  endtask

  initial begin
    int base;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0);
    check_digits("rst", 4'h0, 4'h0);
    check_eq("rst_new", newKey, 1'b0);
    check_eq("rst_held", keyHeld, 1'b0);
    steps(2, 1'b0, 4'h0);

    // Clean press of 5: pulse exactly on step 7, held from step 7
    for (int j = 1; j <= 20; j++) begin
      step(1'b0, 1'b1, 4'h5);
      check_eq("press5_new", newKey, (j == 7) ? 1'b1 : 1'b0);
      check_eq("press5_held", keyHeld, (j >= 7) ? 1'b1 : 1'b0);
      if (j == 7) check_digits("press5", 4'h5, 4'h0);
    end
    check_eq("press5_pulses", pulses, 1);

    // Release: keyHeld falls on step 7
    for (int j = 1; j <= 10; j++) begin
      step(1'b0, 1'b0, 4'h0);
      check_eq("rel_held", keyHeld, (j < 7) ? 1'b1 : 1'b0);
    end

    // Press A, release, press A again
    steps(12, 1'b1, 4'hA);
    check_digits("pressA1", 4'hA, 4'h5);
    steps(10, 1'b0, 4'h0);
    steps(12, 1'b1, 4'hA);
    check_digits("pressA2", 4'hA, 4'hA);
    check_eq("seq_pulses", pulses, 3);
    steps(10, 1'b0, 4'h0);

    // Press bounce: single-cycle toggles then steady key 3
    base = pulses;
    step(1'b0, 1'b1, 4'h3);
    step(1'b0, 1'b0, 4'h3);
    step(1'b0, 1'b1, 4'h3);
    step(1'b0, 1'b0, 4'h3);
    steps(2, 1'b0, 4'h3);
    check_eq("bounce_nopulse", pulses, base);
    check_eq("bounce_cur_before", curDigit, 4'hA);
    steps(12, 1'b1, 4'h3);
    check_eq("bounce_pulses", pulses, base + 1);
    check_digits("bounce", 4'h3, 4'hA);
    steps(10, 1'b0, 4'h0);

    // Key changes during debounce: 7 never registered
    base = pulses;
    steps(3, 1'b1, 4'h7);
    steps(12, 1'b1, 4'h9);
    check_eq("change_pulses", pulses, base + 1);
    check_digits("change", 4'h9, 4'h3);
    steps(10, 1'b0, 4'h0);

    // Hold bounce and roll-over after accepting 2
    steps(12, 1'b1, 4'h2);
    check_digits("press2", 4'h2, 4'h9);
    base = pulses;
    for (int j = 1; j <= 12; j++) begin
      if (j <= 2) step(1'b0, 1'b0, 4'h2);
      else        step(1'b0, 1'b1, 4'h8);
      check_eq("roll_held", keyHeld, 1'b1);
    end
    check_eq("roll_pulses", pulses, base);
    check_digits("roll", 4'h2, 4'h9);
    steps(10, 1'b0, 4'h0);

    // Reset while in DEB_PRESS
    base = pulses;
    steps(4, 1'b1, 4'hC);
    step(1'b1, 1'b1, 4'hC);
    check_digits("rstdeb", 4'h0, 4'h0);
    check_eq("rstdeb_new", newKey, 1'b0);
    check_eq("rstdeb_held", keyHeld, 1'b0);
    step(1'b1, 1'b1, 4'hC);
    check_eq("rstdeb_pulses", pulses, base);

    // Fresh press after reset with normal latency
    for (int j = 1; j <= 10; j++) begin
      step(1'b0, 1'b1, 4'hC);
      check_eq("post_rst_new", newKey, (j == 7) ? 1'b1 : 1'b0);
    end
    check_digits("post_rst", 4'hC, 4'h0);
    check_eq("post_rst_held", keyHeld, 1'b1);

    // Reset while in HELD with curDigit = C
    base = pulses;
    step(1'b1, 1'b1, 4'hC);
    check_digits("rstheld", 4'h0, 4'h0);
    check_eq("rstheld_new", newKey, 1'b0);
    check_eq("rstheld_held", keyHeld, 1'b0);
    steps(8, 1'b0, 4'h0);
    check_eq("rstheld_pulses", pulses, base);
    check_eq("idle_held", keyHeld, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
